// File: rtl/crc6_check.sv
// rtl/crc6_check.sv - serial receive-side CRC-6 and trailer checker for tracker readout frames
// Optional saturating frame error counter on ErrCnt when CRC6_ERRCNT_EN is defined.
module crc6_check #(
  parameter int         LW   = 12,
  parameter int         NTRL = 2,
  parameter logic [5:0] KEY  = 6'b100101
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [LW-1:0] Length,
  input  logic          Din,
  output logic          Dout,
  output logic          DValid,
  output logic          Busy,
  output logic          Done,
  output logic          CrcErr,
  output logic          TrlErr
`ifdef CRC6_ERRCNT_EN
  ,
  output logic [7:0]    ErrCnt
`endif
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    DATA = 4'b0010,
    CRC  = 4'b0100,
    TRL  = 4'b1000
  } state_t;

  state_t        state;
  logic [5:0]    r;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len;
  logic [LW-1:0] cnt_inc;

  assign cnt_inc = cnt + LW'(1);

  function automatic logic [5:0] crc_step(input logic [5:0] cur, input logic d);
    logic fb;
    fb = cur[5] ^ d;
    return {cur[4:0], 1'b0} ^ (fb ? KEY : 6'd0);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      r      <= 6'd0;
      cnt    <= '0;
      len    <= '0;
      Dout   <= 1'b0;
      DValid <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      CrcErr <= 1'b0;
      TrlErr <= 1'b0;
    end else begin
      Done   <= 1'b0;
      Dout   <= 1'b0;
      DValid <= 1'b0;
      // Start wins in every state: a frame in flight is dropped without Done.
      if (Start) begin
        len    <= Length;
        Busy   <= 1'b1;
        TrlErr <= 1'b0;
        if (Length != '0) begin
          r      <= crc_step(6'd0, Din);
          Dout   <= Din;
          DValid <= 1'b1;
          CrcErr <= 1'b0;
          if (Length == LW'(1)) begin
            state <= CRC;
            cnt   <= '0;
          end else begin
            state <= DATA;
            cnt   <= LW'(1);
          end
        end else begin
          // Empty payload: this bit is already CRC bit 5, compared against R=0.
          r      <= 6'd0;
          CrcErr <= Din;
          state  <= CRC;
          cnt    <= LW'(1);
        end
      end else begin
        case (state)
          IDLE: begin
            Busy <= 1'b0;
            cnt  <= '0;
          end
          DATA: begin
            r      <= crc_step(r, Din);
            Dout   <= Din;
            DValid <= 1'b1;
            if (cnt_inc == len) begin
              state <= CRC;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          CRC: begin
            CrcErr <= CrcErr | (Din ^ r[5]);
            r      <= {r[4:0], 1'b0};
            if (cnt_inc == LW'(6)) begin
              state <= TRL;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          TRL: begin
            TrlErr <= TrlErr | ~Din;
            if (cnt_inc == LW'(NTRL)) begin
              state <= IDLE;
              cnt   <= '0;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CRC6_ERRCNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ErrCnt <= 8'd0;
    end else if (Done && (CrcErr || TrlErr) && (ErrCnt != 8'hFF)) begin
      ErrCnt <= ErrCnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc6_check.sv
// tb/tb_crc6_check.sv - directed table-driven bench for crc6_check
// Covers the CRC6_ERRCNT_EN counter when that macro is defined.
module tb_crc6_check;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [11:0] Length;
  logic        Din;
  logic        Dout, DValid, Busy, Done, CrcErr, TrlErr;
`ifdef CRC6_ERRCNT_EN
  logic [7:0]  ErrCnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_errcnt = 0;

  always #5 Clock = ~Clock;

  crc6_check #(.LW(12), .NTRL(2), .KEY(6'b100101)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length), .Din(Din),
    .Dout(Dout), .DValid(DValid), .Busy(Busy), .Done(Done),
    .CrcErr(CrcErr), .TrlErr(TrlErr)
`ifdef CRC6_ERRCNT_EN
    , .ErrCnt(ErrCnt)
`endif
  );

  typedef struct {
    int          len;
    int          nbits;
    logic [31:0] frame;
    logic        ecrc;
    logic        etrl;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int          dv_cnt, done_at, busy_bad, dout_bad;
    logic [31:0] dw, exp_data;
    dv_cnt = 0; done_at = -1; busy_bad = 0; dout_bad = 0; dw = 0;
    exp_data = v.frame >> (v.nbits - v.len);
    for (int i = 0; i < v.nbits; i++) begin
      Start  = (i == 0);
      Din    = v.frame[v.nbits-1-i];
      Length = (i == 0) ? 12'(v.len) : 12'hABC;
      @(posedge Clock); #1;
      if (DValid) begin
        dw = {dw[30:0], Dout};
        dv_cnt++;
      end else if (Dout) begin
        dout_bad++;
      end
      if (DValid != (i < v.len)) dout_bad++;
      if (Done && done_at < 0) done_at = i;
      if (Busy != (i < v.nbits - 1)) busy_bad++;
    end
    Start = 1'b0;
    Din   = 1'b1;
    check({tag, "_done_at"}, done_at, v.nbits - 1);
    check({tag, "_dout"}, dw, exp_data);
    check({tag, "_dvalid_cnt"}, dv_cnt, v.len);
    check({tag, "_dout_gating"}, dout_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_crcerr"}, CrcErr, v.ecrc);
    check({tag, "_trlerr"}, TrlErr, v.etrl);
    if (v.ecrc || v.etrl) exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
  endtask

  task automatic idle_check(input logic ecrc, input logic etrl, input string tag);
    Start = 1'b0; Din = 1'b1;
    @(posedge Clock); #1;
    check({tag, "_done_pulse"}, Done, 0);
    check({tag, "_crcerr_hold"}, CrcErr, ecrc);
    check({tag, "_trlerr_hold"}, TrlErr, etrl);
  endtask

  // Drives the first count bits of a frame and returns how many Done pulses appeared.
  task automatic send_partial(input vec_t v, input int count, output int ndone);
    ndone = 0;
    for (int i = 0; i < count; i++) begin
      Start  = (i == 0);
      Din    = v.frame[v.nbits-1-i];
      Length = (i == 0) ? 12'(v.len) : 12'h5A5;
      @(posedge Clock); #1;
      if (Done) ndone++;
    end
  endtask

  initial begin
    int ndone;
    vecs[0] = '{8, 16, 32'b1000_0000_0010_1111, 1'b0, 1'b0};
    vecs[1] = '{8, 16, 32'b1001_0000_0010_1111, 1'b1, 1'b0};
    vecs[2] = '{8, 16, 32'b1000_0000_0010_1110, 1'b0, 1'b1};
    vecs[3] = '{0,  8, 32'b0000_0011,           1'b0, 1'b0};
    vecs[4] = '{0,  8, 32'b0000_0111,           1'b1, 1'b0};
    vecs[5] = '{4, 12, 32'b1010_1111_0011,      1'b0, 1'b0};
    vecs[6] = '{3, 11, 32'b011_0010_1011,       1'b0, 1'b0};
    vecs[7] = '{1,  9, 32'b1_1001_0101,         1'b0, 1'b1};
    vecs[8] = '{4, 12, 32'b1010_1111_0000,      1'b0, 1'b1};

    Reset = 1'b1; Start = 1'b0; Din = 1'b0; Length = 12'd0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("rst_outputs", {Dout, DValid, Busy, Done, CrcErr, TrlErr}, 6'b0);
`ifdef CRC6_ERRCNT_EN
    check("rst_errcnt", ErrCnt, 0);
`endif

    for (int k = 0; k < 9; k++) begin
      run_frame(vecs[k], $sformatf("v%0d", k));
      idle_check(vecs[k].ecrc, vecs[k].etrl, $sformatf("v%0d", k));
    end

    // Start in the Done cycle of the previous frame.
    run_frame(vecs[1], "b2b_a");
    run_frame(vecs[2], "b2b_b");
    run_frame(vecs[0], "b2b_c");
    idle_check(1'b0, 1'b0, "b2b_c");

    // Reset asserted while bit 4 of a frame is on Din.
    send_partial(vecs[0], 4, ndone);
    Reset = 1'b1; Din = 1'b0; Start = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_errcnt = 0;
    check("midrst_outputs", {Dout, DValid, Busy, Done, CrcErr, TrlErr}, 6'b0);
    ndone = 0;
    Din = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge Clock); #1;
      if (Done || Busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_frame(vecs[0], "midrst_next");

    // New Start arriving at bit 5 of a bad frame aborts it.
    run_frame(vecs[4], "pre_abort");
    send_partial(vecs[1], 5, ndone);
    check("abort_early_done", ndone, 0);
    run_frame(vecs[0], "abort_next");
    idle_check(1'b0, 1'b0, "abort_next");

`ifdef CRC6_ERRCNT_EN
    check("errcnt_before_sat", ErrCnt, exp_errcnt);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 8; i++) begin
        Start = (i == 0);
        Din   = vecs[4].frame[7-i];
        Length = 12'd0;
        @(posedge Clock);
      end
    end
    Start = 1'b0; Din = 1'b1;
    @(posedge Clock); #1;
    check("errcnt_sat", ErrCnt, 8'hFF);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("errcnt_reset", ErrCnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
